// File: rtl/model_write_heads_pkg.sv
// Shared types for the DNC write-head sequencer: FSM states, stage codes
// and the fixed order in which the six parameter units are loaded.
package model_write_heads_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_X_LOAD,
    S_X_WAIT,
    S_V_START,
    S_V_STREAM,
    S_V_WAIT,
    S_DONE
  } state_t;

  localparam logic [2:0] STAGE_IDLE = 3'd0;
  localparam logic [2:0] STAGE_WS   = 3'd1;
  localparam logic [2:0] STAGE_AG   = 3'd2;
  localparam logic [2:0] STAGE_WG   = 3'd3;
  localparam logic [2:0] STAGE_WK   = 3'd4;
  localparam logic [2:0] STAGE_EV   = 3'd5;
  localparam logic [2:0] STAGE_WV   = 3'd6;
  localparam logic [2:0] STAGE_DONE = 3'd7;

  // Successor of each stage code, indexed by the current stage.
  localparam logic [2:0] STAGE_ORDER [0:7] = '{
    STAGE_WS, STAGE_AG, STAGE_WG, STAGE_WK,
    STAGE_EV, STAGE_WV, STAGE_DONE, STAGE_IDLE
  };

  function automatic logic is_vector_stage(input logic [2:0] s);
    return (s == STAGE_WK) || (s == STAGE_EV) || (s == STAGE_WV);
  endfunction

endpackage

// File: rtl/model_write_heads_vector_feeder.sv
// Shared element streamer for the WK/EV/WV units: start pulse, element
// counter, registered data/strobe and last-element detect.
module model_write_heads_vector_feeder #(
  parameter int DATA_SIZE = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 launch,
  input  logic                 xfer,
  input  logic [DATA_SIZE-1:0] xi,
  input  logic [DATA_SIZE-1:0] size_w,
  output logic                 unit_start,
  output logic                 strobe,
  output logic [DATA_SIZE-1:0] data,
  output logic                 last
);

  localparam logic [DATA_SIZE-1:0] ONE = DATA_SIZE'(1);

  logic [DATA_SIZE-1:0] count_q;
  logic                 strobe_q;
  logic [DATA_SIZE-1:0] data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q  <= '0;
      strobe_q <= 1'b0;
      data_q   <= '0;
    end else begin
      strobe_q <= xfer;
      if (launch) begin
        count_q <= '0;
      end else if (xfer) begin
        count_q <= count_q + ONE;
      end
      if (xfer) begin
        data_q <= xi;
      end
    end
  end

  // Only meaningful while streaming, where size_w is known to be non-zero.
  assign last       = (count_q == size_w - ONE);
  assign unit_start = launch;
  assign strobe     = strobe_q;
  assign data       = data_q;

endmodule

// File: rtl/model_write_heads_controller.sv
// Loads the six DNC write-head units in fixed order from one xi word stream
// and pulses READY once every unit has reported completion.
module model_write_heads_controller
  import model_write_heads_pkg::*;
#(
  parameter int DATA_SIZE    = 64,
  parameter int CONTROL_SIZE = 64
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  output logic                 READY,
  input  logic [DATA_SIZE-1:0] SIZE_W_IN,
  input  logic                 XI_IN_ENABLE,
  output logic                 XI_IN_ACCEPT,
  input  logic [DATA_SIZE-1:0] XI_IN,
  output logic [2:0]           STAGE,
  output logic                 WS_START,
  output logic                 AG_START,
  output logic                 WG_START,
  input  logic                 WS_READY,
  input  logic                 AG_READY,
  input  logic                 WG_READY,
  output logic [DATA_SIZE-1:0] WS_BETA_IN,
  output logic [DATA_SIZE-1:0] AG_GA_IN,
  output logic [DATA_SIZE-1:0] WG_GW_IN,
  output logic                 WK_START,
  output logic                 EV_START,
  output logic                 WV_START,
  input  logic                 WK_READY,
  input  logic                 EV_READY,
  input  logic                 WV_READY,
  output logic                 WK_K_IN_ENABLE,
  output logic                 EV_E_IN_ENABLE,
  output logic                 WV_V_IN_ENABLE,
  output logic [DATA_SIZE-1:0] WK_SIZE_W_IN,
  output logic [DATA_SIZE-1:0] EV_SIZE_W_IN,
  output logic [DATA_SIZE-1:0] WV_SIZE_W_IN,
  output logic [DATA_SIZE-1:0] WK_K_IN,
  output logic [DATA_SIZE-1:0] EV_E_IN,
  output logic [DATA_SIZE-1:0] WV_V_IN
);

  state_t               state_q, state_d;
  logic [2:0]           stage_q, stage_d, stage_nxt;
  logic [DATA_SIZE-1:0] w_q, ws_q, ag_q, wg_q;
  logic                 x_start_q;
  logic                 accept, xfer, unit_ready;
  logic                 fd_start, fd_strobe, fd_last;
  logic [DATA_SIZE-1:0] fd_data;
  logic [CONTROL_SIZE-1:0] unused_control;

  assign unused_control = '0;

  // Valid/ready: a word moves when XI_IN_ENABLE && XI_IN_ACCEPT; ACCEPT is
  // decoded from the registered state only and never looks at ENABLE.
  assign accept = (state_q == S_X_LOAD) || (state_q == S_V_STREAM);
  assign xfer   = XI_IN_ENABLE && accept;

  always_comb begin
    unit_ready = 1'b0;
    case (stage_q)
      STAGE_WS: unit_ready = WS_READY;
      STAGE_AG: unit_ready = AG_READY;
      STAGE_WG: unit_ready = WG_READY;
      STAGE_WK: unit_ready = WK_READY;
      STAGE_EV: unit_ready = EV_READY;
      STAGE_WV: unit_ready = WV_READY;
      default:  unit_ready = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      stage_q <= STAGE_IDLE;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    stage_d   = stage_q;
    stage_nxt = STAGE_ORDER[stage_q];
    case (state_q)
      S_IDLE: begin
        if (START) begin
          state_d = S_X_LOAD;
          stage_d = STAGE_WS;
        end
      end
      S_X_LOAD: if (xfer) state_d = S_X_WAIT;
      S_X_WAIT, S_V_WAIT: begin
        if (unit_ready) begin
          // With W=0 every vector stage is skipped, so go straight to DONE.
          if (stage_nxt == STAGE_DONE || (is_vector_stage(stage_nxt) && w_q == '0)) begin
            state_d = S_DONE;
            stage_d = STAGE_DONE;
          end else if (is_vector_stage(stage_nxt)) begin
            state_d = S_V_START;
            stage_d = stage_nxt;
          end else begin
            state_d = S_X_LOAD;
            stage_d = stage_nxt;
          end
        end
      end
      S_V_START:  state_d = S_V_STREAM;
      S_V_STREAM: if (xfer && fd_last) state_d = S_V_WAIT;
      S_DONE: begin
        state_d = S_IDLE;
        stage_d = STAGE_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        stage_d = STAGE_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      w_q       <= '0;
      ws_q      <= '0;
      ag_q      <= '0;
      wg_q      <= '0;
      x_start_q <= 1'b0;
    end else begin
      x_start_q <= (state_q == S_X_LOAD) && xfer;
      if (state_q == S_IDLE && START) w_q <= SIZE_W_IN;
      if (state_q == S_X_LOAD && xfer) begin
        if (stage_q == STAGE_WS) ws_q <= XI_IN;
        if (stage_q == STAGE_AG) ag_q <= XI_IN;
        if (stage_q == STAGE_WG) wg_q <= XI_IN;
      end
    end
  end

  model_write_heads_vector_feeder #(
    .DATA_SIZE(DATA_SIZE)
  ) u_feeder (
    .clk       (CLK),
    .rst       (RST),
    .launch    (state_q == S_V_START),
    .xfer      (xfer && (state_q == S_V_STREAM)),
    .xi        (XI_IN),
    .size_w    (w_q),
    .unit_start(fd_start),
    .strobe    (fd_strobe),
    .data      (fd_data),
    .last      (fd_last)
  );

  assign READY        = (state_q == S_DONE);
  assign XI_IN_ACCEPT = accept;
  assign STAGE        = stage_q;

  assign WS_START   = x_start_q && (stage_q == STAGE_WS);
  assign AG_START   = x_start_q && (stage_q == STAGE_AG);
  assign WG_START   = x_start_q && (stage_q == STAGE_WG);
  assign WS_BETA_IN = ws_q;
  assign AG_GA_IN   = ag_q;
  assign WG_GW_IN   = wg_q;

  // One feeder serves all vector units; start and strobe are steered by stage.
  assign WK_START       = fd_start  && (stage_q == STAGE_WK);
  assign EV_START       = fd_start  && (stage_q == STAGE_EV);
  assign WV_START       = fd_start  && (stage_q == STAGE_WV);
  assign WK_K_IN_ENABLE = fd_strobe && (stage_q == STAGE_WK);
  assign EV_E_IN_ENABLE = fd_strobe && (stage_q == STAGE_EV);
  assign WV_V_IN_ENABLE = fd_strobe && (stage_q == STAGE_WV);
  assign WK_SIZE_W_IN   = w_q;
  assign EV_SIZE_W_IN   = w_q;
  assign WV_SIZE_W_IN   = w_q;
  assign WK_K_IN        = fd_data;
  assign EV_E_IN        = fd_data;
  assign WV_V_IN        = fd_data;

endmodule

// File: doc/model_write_heads_controller.md
Name: model_write_heads_controller

Overview:
Sequencer for the DNC write-head parameter units: write strength, allocation gate, write gate, write key, erase vector and write vector.
- Consumes one upstream interface-vector word stream.
- Starts each unit in a fixed order, feeds it its scalar or W-element vector, and waits for its READY before moving on.
- Pulses READY once all six units have completed.
- Sits between the controller-output (xi) splitter and the write-head units.

Parameters:
DATA_SIZE, 64, width of data words and of SIZE_W_IN / element counter
CONTROL_SIZE, 64, control width passed through to units (unused internally)

Ports:
CLK  in  1  clock
RST  in  1  asynchronous active-high reset
START  in  1  one-cycle request to run a full write-head load
READY  out  1  one-cycle pulse when all units done
SIZE_W_IN  in  DATA_SIZE  vector length W, latched on START
XI_IN_ENABLE  in  1  upstream word valid
XI_IN_ACCEPT  out  1  controller can take a word this cycle
XI_IN  in  DATA_SIZE  upstream word
STAGE  out  3  current stage code (debug)
WS_START/AG_START/WG_START  out  1  scalar unit start pulses
WS_READY/AG_READY/WG_READY  in  1  scalar unit done
WS_BETA_IN/AG_GA_IN/WG_GW_IN  out  DATA_SIZE  scalar unit data, held
WK_START/EV_START/WV_START  out  1  vector unit start pulses
WK_READY/EV_READY/WV_READY  in  1  vector unit done
WK_K_IN_ENABLE/EV_E_IN_ENABLE/WV_V_IN_ENABLE  out  1  element strobe
WK_SIZE_W_IN/EV_SIZE_W_IN/WV_SIZE_W_IN  out  DATA_SIZE  latched W
WK_K_IN/EV_E_IN/WV_V_IN  out  DATA_SIZE  element data

Behaviour:
- Clock and reset: one clock, CLK; RST is asynchronous and active-high.
- Reset values: state IDLE; STAGE=0; all outputs, W latch and element counter 0.
- Reset mid-operation aborts immediately; no pending pulses are emitted afterwards.
- Upstream word order: beta, ga, gw, k[0..W-1], e[0..W-1], v[0..W-1].
- Transfer rule: a word transfers when XI_IN_ENABLE && XI_IN_ACCEPT. XI_IN_ACCEPT is decoded from the registered state only (Moore), never from XI_IN_ENABLE.
- Stage codes: 0 IDLE, 1 WS, 2 AG, 3 WG, 4 WK, 5 EV, 6 WV, 7 DONE.
- IDLE: ACCEPT=0. When START=1, latch SIZE_W_IN into W; go to WS_LOAD. START is ignored in every other state.
- Scalar stage X_LOAD (WS, AG, WG): ACCEPT=1.
  - On transfer, register XI_IN onto the unit data port.
  - X_START pulses high the following cycle.
  - Go to X_WAIT.
- X_WAIT: ACCEPT=0; data port held. On unit READY go to the next stage.
  - READY arriving in the same cycle as the START pulse counts.
  - READY outside the unit's WAIT state is ignored.
- Vector stage entry (WK, EV, WV):
  - If W=0, skip the stage entirely: no START, no strobes.
  - Otherwise go to V_START, pulse unit START for 1 cycle with SIZE_W_IN driven to W, clear the counter, then go to V_STREAM.
- V_STREAM: ACCEPT=1.
  - Each transfer registers XI_IN to the data port and pulses IN_ENABLE the next cycle; the counter increments.
  - After the transfer with counter=W-1, ACCEPT drops next cycle; go to V_WAIT.
- Back-pressure: with XI_IN_ENABLE=0 the controller stalls in LOAD/STREAM indefinitely. No timeout.
- V_WAIT: on unit READY, advance (WK→EV→WV→DONE).
- DONE: READY=1 for exactly one cycle, then IDLE. A new START is accepted the cycle after READY.
- Best-case latency: scalar stage 2 cycles plus unit latency; vector stage 1 + W cycles plus unit latency.
- Counter compares at full DATA_SIZE width; no wrap within a run.
- SIZE_W_IN changes after latching have no effect until the next START.

Decomposition:
- Package model_write_heads_pkg:
  - state enum (IDLE, X_LOAD, X_WAIT, V_START, V_STREAM, V_WAIT, DONE);
  - stage codes 0–7;
  - stage-order constant.
- One sub-module, model_write_heads_vector_feeder: START pulse, element counter, IN_ENABLE strobe and last-element detect. It is instantiated once and its outputs are demuxed to WK/EV/WV by stage.

Test Plan:
- Nominal: W=4, 15 words 0x1..0xF always valid, units READY 3 cycles after START/last strobe → WS_BETA_IN=1, AG=2, WG=3; WK gets 4..7, EV 8..11, WV 12..15; exactly 4 strobes per vector unit; single READY pulse; STAGE steps 1→7→0.
- Back-pressure: W=2, XI_IN_ENABLE toggles 1/0 → no word lost or duplicated; strobes occur only after transfers; final outputs WV_V_IN=last word.
- W=0: START with SIZE_W_IN=0 → only WS/AG/WG start; no WK/EV/WV START or strobes; READY after WG_READY+1 cycle.
- Early/spurious READY: assert WK_READY during WG_WAIT, then WG_READY → WK_READY is ignored; WK stage still streams and waits for its own READY.
- Reset mid-stream: RST asserted during EV streaming, element 1 of W=4 → all outputs 0 asynchronously; no READY; a fresh START afterwards runs the full sequence correctly.
- Back-to-back: START asserted the cycle after READY with W=1 → second run accepted; START pulses during a run are ignored.
